// File: rtl/addsub_arb_pkg.sv
// rtl/addsub_arb_pkg.sv - shared types and constants for the add/sub arbiter
package addsub_arb_pkg;

  // Controller sequence: accept a request, drive the datapath once, present the result
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_N_REQ = 4;

endpackage

// File: rtl/add_sub.sv
// rtl/add_sub.sv - shared add/subtract unit (sel=0 A+B, sel=1 A-B) with carry and signed overflow
module add_sub
  import addsub_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sel,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf
);

  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH:0]   w_full;

  // Subtract is A + ~B + 1, so carry-out of 1 means no borrow
  always_comb begin
    w_b_eff = (i_sel == OP_SUB) ? ~i_b : i_b;
    w_full  = {1'b0, i_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, i_sel};
    o_sum   = w_full[WIDTH-1:0];
    o_cout  = w_full[WIDTH];
    o_ovf   = (i_a[WIDTH-1] == w_b_eff[WIDTH-1]) && (o_sum[WIDTH-1] != i_a[WIDTH-1]);
  end

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting just after the pointer
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_gnt,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  // Scan ptr+1 .. ptr+N (mod N); the first active request wins
  always_comb begin
    logic v_found;
    o_gnt   = '0;
    o_idx   = '0;
    v_found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      for (int p = 0; p < N; p++) begin
        if (!v_found && i_req[p] && (p == ((int'(i_ptr) + k) % N))) begin
          o_gnt[p] = 1'b1;
          o_idx    = IDX_W'(p);
          v_found  = 1'b1;
        end
      end
    end
  end

  assign o_any = |i_req;

endmodule

// File: rtl/addsub_arbiter.sv
// rtl/addsub_arbiter.sv - round-robin sharing of one add_sub unit; ADDSUB_ARB_SAT_EN enables result saturation
module addsub_arbiter
  import addsub_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int WIDTH = DEF_WIDTH,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  input  logic [N_REQ-1:0]   req_sel,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [ID_W-1:0]    resp_id,
  output logic [WIDTH-1:0]   resp_sum,
  output logic               resp_cout,
  output logic               resp_ovf
);

  state_t           r_state;
  state_t           w_next;

  logic [ID_W-1:0]  r_ptr;
  logic [ID_W-1:0]  r_id;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_sel;

  logic [ID_W-1:0]  r_resp_id;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic [N_REQ-1:0] w_gnt;
  logic [ID_W-1:0]  w_gidx;
  logic             w_any;
  logic             w_accept;

  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic             w_sel;

  logic [WIDTH-1:0] w_au_sum;
  logic             w_au_cout;
  logic             w_au_ovf;
  logic [WIDTH-1:0] w_res_sum;

  rr_arbiter #(
    .N     (N_REQ),
    .IDX_W (ID_W)
  ) u_rr (
    .i_req (req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_gidx),
    .o_any (w_any)
  );

  // Select the granted requester's operands from the packed buses
  always_comb begin
    w_a   = '0;
    w_b   = '0;
    w_sel = OP_ADD;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_gnt[i]) begin
        w_a   = req_a[i*WIDTH +: WIDTH];
        w_b   = req_b[i*WIDTH +: WIDTH];
        w_sel = req_sel[i];
      end
    end
  end

  add_sub #(
    .WIDTH (WIDTH)
  ) u_add_sub (
    .i_a    (r_a),
    .i_b    (r_b),
    .i_sel  (r_sel),
    .o_sum  (w_au_sum),
    .o_cout (w_au_cout),
    .o_ovf  (w_au_ovf)
  );

`ifdef ADDSUB_ARB_SAT_EN
  // Clamp on overflow; the sign of A tells which way the result overflowed
  always_comb begin
    w_res_sum = w_au_sum;
    if (w_au_ovf) begin
      w_res_sum = r_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  assign w_res_sum = w_au_sum;
`endif

  // Next state and grant pulse; grants are only offered while idle
  always_comb begin
    w_next    = r_state;
    req_ready = '0;
    unique case (r_state)
      IDLE: begin
        if (w_any) begin
          req_ready = w_gnt;
          w_next    = EXEC;
        end
      end
      EXEC: w_next = RESP;
      RESP: begin
        if (resp_ready) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_accept = (r_state == IDLE) && w_any;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Operand latch at grant, pointer update, and result capture after the execute cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr     <= ID_W'(N_REQ - 1);
      r_id      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_sel     <= OP_ADD;
      r_resp_id <= '0;
      r_sum     <= '0;
      r_cout    <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a   <= w_a;
        r_b   <= w_b;
        r_sel <= w_sel;
        r_id  <= w_gidx;
        r_ptr <= w_gidx;
      end
      if (r_state == EXEC) begin
        r_resp_id <= r_id;
        r_sum     <= w_res_sum;
        r_cout    <= w_au_cout;
        r_ovf     <= w_au_ovf;
      end
    end
  end

  assign resp_valid = (r_state == RESP);
  assign resp_id    = r_resp_id;
  assign resp_sum   = r_sum;
  assign resp_cout  = r_cout;
  assign resp_ovf   = r_ovf;

endmodule

// File: doc/addsub_arbiter.md
Name: addsub_arbiter

Overview:
Shares one 16-bit add/subtract datapath (existing add_sub unit: sel=0 add, sel=1 A-B) between N_REQ requesters.
Requesters are granted round-robin through a valid/ready handshake. Operands are registered and the unit is driven for one execute cycle. The sum, carry-out and signed overflow are returned with the requester's ID over a valid/ready response channel.
Sits between the ALU-issue logic and the shared add_sub instance.

Parameters:
N_REQ, 4, number of requesters (2..8)
WIDTH, 16, operand/result width
ID_W, $clog2(N_REQ), width of resp_id

Ports:
clk  in  1  single clock
rst  in  1  synchronous, active-high reset
req_valid  in  N_REQ  per-requester request
req_ready  out  N_REQ  one-hot grant/accept pulse
req_a  in  N_REQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
req_b  in  N_REQ*WIDTH  operand B, same packing
req_sel  in  N_REQ  0=add, 1=subtract
resp_valid  out  1  result available
resp_ready  in  1  consumer accepts result
resp_id  out  ID_W  index of granted requester
resp_sum  out  WIDTH  result
resp_cout  out  1  carry-out (subtract: carry of A+~B+1)
resp_ovf  out  1  signed two's-complement overflow

Behaviour:
- Reset (sync, rst=1 at posedge): state=IDLE; rr_ptr=N_REQ-1 (requester 0 highest priority first); req_ready=0; resp_valid=0; resp_id/resp_sum/resp_cout/resp_ovf=0. An in-flight operation is discarded and no response is issued.
- FSM: IDLE -> EXEC -> RESP -> IDLE.
- IDLE, any req_valid=1:
  - Pick the first valid index scanning rr_ptr+1 .. rr_ptr+N_REQ (mod N_REQ).
  - req_ready[g]=1 combinationally in this cycle only.
  - At the clock edge: latch a, b, sel and g; set rr_ptr=g; go to EXEC.
- IDLE, no valid: stay; req_ready=0.
- EXEC: latched operands drive add_sub. Sum, cout and V are captured into the response registers at the edge; go to RESP.
- RESP: resp_valid=1. Outputs stay stable until resp_valid&&resp_ready, then go to IDLE.
- All req_ready=0 outside IDLE.
- Latency: handshake at edge T -> resp_valid high from T+2. Minimum 3 cycles per operation; a same-cycle new grant in RESP is not allowed.
- Requester rule: req_valid and operands are held until req_ready. Dropping valid before grant is legal; that requester is simply skipped.
- Arithmetic:
  - Modulo 2^WIDTH.
  - Add: cout = carry out of A+B.
  - Sub: cout = carry out of A+~B+1 (1 = no borrow).
  - ovf=1 when the operand signs (B inverted for sub) agree and the result sign differs.
- Boundaries:
  - All requesters valid: grants rotate 0,1,2,3,0...
  - A single persistent requester is re-granted every op.
  - resp_ready held low: stall in RESP indefinitely, no new grants.
  - rst asserted in EXEC or RESP: return to IDLE next edge, response dropped, rr_ptr reset.

Optional Feature:
ADDSUB_ARB_SAT_EN:
- When defined and resp_ovf=1, resp_sum saturates: positive overflow -> {0,{WIDTH-1{1}}}, negative overflow -> {1,{WIDTH-1{0}}}. resp_ovf still reports 1; resp_cout is unchanged.
- Without the macro: wrapped modulo result. No saturation logic is present.

Decomposition:
- Package addsub_arb_pkg: state enum (IDLE, EXEC, RESP); constants OP_ADD=1'b0, OP_SUB=1'b1; default WIDTH/N_REQ.
- Sub-module rr_arbiter: parameterised round-robin pick.
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant, encoded index, any_req.
  - Combinational, reusable by other shared-resource controllers.
- The existing add_sub unit is instantiated, not reimplemented.

Test Plan:
- Req0 A=0x0000 B=0x0101 sel=0 -> resp_valid at T+2, id=0, sum=0x0101, cout=0, ovf=0.
- Req1 A=0x0101 B=0x0101 sel=1 -> sum=0x0000, cout=1, ovf=0; req_ready pulses exactly one cycle.
- Req2 A=0xFEFE B=0xF1F1 sel=0 -> sum=0xF0EF, cout=1, ovf=0.
- Req3 A=0x7FFF B=0x0001 sel=0 -> sum=0x8000, ovf=1. With ADDSUB_ARB_SAT_EN: sum=0x7FFF, ovf=1.
- All four req_valid continuously after reset, resp_ready=1 -> resp_id sequence 0,1,2,3,0. Hold resp_ready=0 for 5 cycles -> outputs stable, all req_ready=0.
- Pulse rst during EXEC -> no resp_valid. Next grant goes to req0 when all are requesting.
